// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared types and widths for the 8-bit Wishbone SRAM bridge
// Contents: FSM state encoding, SRAM address/data widths, Wishbone byte address width.
package sram_pkg;

  localparam int SRAM_AW = 16;
  localparam int SRAM_DW = 16;
  localparam int WB_AW   = SRAM_AW + 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WRITE = 3'd2,
    ST_WHOLD = 3'd3,
    ST_ACK   = 3'd4
  } state_t;

endpackage

// File: rtl/sram_wb8_if.sv
// rtl/sram_wb8_if.sv - 8-bit Wishbone slave bus bundle
// Signals: STB_I strobe, WE_I write enable, ADR_I byte address, DAT_I write data,
//          DAT_O read data, ACK_O completion pulse.
// Modports: master drives the request side, slave drives DAT_O/ACK_O.
interface sram_wb8_if;
  import sram_pkg::*;

  logic             STB_I;
  logic             WE_I;
  logic [WB_AW-1:0] ADR_I;
  logic [7:0]       DAT_I;
  logic [7:0]       DAT_O;
  logic             ACK_O;

  modport master (
    output STB_I, WE_I, ADR_I, DAT_I,
    input  DAT_O, ACK_O
  );

  modport slave (
    input  STB_I, WE_I, ADR_I, DAT_I,
    output DAT_O, ACK_O
  );

endinterface

// File: rtl/sram_wb8.sv
// rtl/sram_wb8.sv - 8-bit Wishbone slave bridging to a 64Kx16 asynchronous SRAM
// Parameter: WAIT_CYCLES (1..15) cycles the OE/WE strobe is held active.
// Ports: CLK_I clock, RST_I async active-low reset, wb Wishbone slave bundle,
//        O_sram_adr/ce_n/oe_n/we_n/ub_n/lb_n registered SRAM controls,
//        O_sram_dat/O_sram_dat_oe pad write data and drive enable, I_sram_dat pad read data.
module sram_wb8
  import sram_pkg::*;
#(
  parameter int WAIT_CYCLES = 1
) (
  input  logic               CLK_I,
  input  logic               RST_I,
  sram_wb8_if.slave          wb,
  output logic [SRAM_AW-1:0] O_sram_adr,
  output logic               O_sram_ce_n,
  output logic               O_sram_oe_n,
  output logic               O_sram_we_n,
  output logic               O_sram_ub_n,
  output logic               O_sram_lb_n,
  output logic [SRAM_DW-1:0] O_sram_dat,
  output logic               O_sram_dat_oe,
  input  logic [SRAM_DW-1:0] I_sram_dat
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  state_t     state;
  logic [3:0] cnt;

  // Every output is a register; strobes for the next state are set on the
  // transition into it so the pins are glitch-free and aligned to cycle edges.
  // The terminal test is cnt <= 1 so an out-of-range load of 0 behaves like 1.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state         <= ST_IDLE;
      cnt           <= 4'd0;
      O_sram_adr    <= '0;
      O_sram_ce_n   <= 1'b1;
      O_sram_oe_n   <= 1'b1;
      O_sram_we_n   <= 1'b1;
      O_sram_ub_n   <= 1'b1;
      O_sram_lb_n   <= 1'b1;
      O_sram_dat    <= '0;
      O_sram_dat_oe <= 1'b0;
      wb.DAT_O      <= 8'h00;
      wb.ACK_O      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          wb.ACK_O <= 1'b0;
          if (wb.STB_I) begin
            O_sram_adr  <= wb.ADR_I[WB_AW-1:1];
            O_sram_ce_n <= 1'b0;
            O_sram_lb_n <= wb.ADR_I[0];
            O_sram_ub_n <= ~wb.ADR_I[0];
            cnt         <= WAIT_LOAD;
            if (wb.WE_I) begin
              // Both lanes carry the byte; only the selected lane strobe goes low.
              O_sram_dat    <= {wb.DAT_I, wb.DAT_I};
              O_sram_dat_oe <= 1'b1;
              O_sram_we_n   <= 1'b0;
              O_sram_oe_n   <= 1'b1;
              state         <= ST_WRITE;
            end else begin
              O_sram_oe_n <= 1'b0;
              state       <= ST_READ;
            end
          end
        end

        ST_READ: begin
          if (cnt <= 4'd1) begin
            wb.DAT_O    <= O_sram_ub_n ? I_sram_dat[7:0] : I_sram_dat[15:8];
            wb.ACK_O    <= 1'b1;
            O_sram_ce_n <= 1'b1;
            O_sram_oe_n <= 1'b1;
            O_sram_ub_n <= 1'b1;
            O_sram_lb_n <= 1'b1;
            state       <= ST_ACK;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        ST_WRITE: begin
          if (cnt <= 4'd1) begin
            // WE rises first; CE, lane and data stay put one more cycle for hold.
            O_sram_we_n <= 1'b1;
            state       <= ST_WHOLD;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        ST_WHOLD: begin
          wb.ACK_O      <= 1'b1;
          O_sram_ce_n   <= 1'b1;
          O_sram_ub_n   <= 1'b1;
          O_sram_lb_n   <= 1'b1;
          O_sram_dat_oe <= 1'b0;
          state         <= ST_ACK;
        end

        ST_ACK: begin
          wb.ACK_O <= 1'b0;
          state    <= ST_IDLE;
        end

        default: begin
          wb.ACK_O      <= 1'b0;
          O_sram_ce_n   <= 1'b1;
          O_sram_oe_n   <= 1'b1;
          O_sram_we_n   <= 1'b1;
          O_sram_ub_n   <= 1'b1;
          O_sram_lb_n   <= 1'b1;
          O_sram_dat_oe <= 1'b0;
          state         <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_wb8.sv
// tb/tb_sram_wb8.sv - directed self-checking bench for sram_wb8 with a behavioural byte-lane SRAM
module tb_sram_wb8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Shared request drivers; sel routes the strobe to the N=1 (0) or N=3 (1) instance.
  logic        stb = 1'b0;
  logic        we = 1'b0;
  logic [16:0] adr = '0;
  logic [7:0]  dat = '0;
  logic        sel = 1'b0;

  logic [15:0] mem [0:65535];

  sram_wb8_if wb1();
  sram_wb8_if wb3();

  assign wb1.STB_I = stb && !sel;
  assign wb1.WE_I  = we;
  assign wb1.ADR_I = adr;
  assign wb1.DAT_I = dat;
  assign wb3.STB_I = stb && sel;
  assign wb3.WE_I  = we;
  assign wb3.ADR_I = adr;
  assign wb3.DAT_I = dat;

  logic [15:0] d1_adr, d1_dat, d1_in, d3_adr, d3_dat, d3_in;
  logic d1_ce_n, d1_oe_n, d1_we_n, d1_ub_n, d1_lb_n, d1_doe;
  logic d3_ce_n, d3_oe_n, d3_we_n, d3_ub_n, d3_lb_n, d3_doe;

  sram_wb8 #(.WAIT_CYCLES(1)) dut1 (
    .CLK_I(clk), .RST_I(rst_n), .wb(wb1.slave),
    .O_sram_adr(d1_adr), .O_sram_ce_n(d1_ce_n), .O_sram_oe_n(d1_oe_n),
    .O_sram_we_n(d1_we_n), .O_sram_ub_n(d1_ub_n), .O_sram_lb_n(d1_lb_n),
    .O_sram_dat(d1_dat), .O_sram_dat_oe(d1_doe), .I_sram_dat(d1_in)
  );

  sram_wb8 #(.WAIT_CYCLES(3)) dut3 (
    .CLK_I(clk), .RST_I(rst_n), .wb(wb3.slave),
    .O_sram_adr(d3_adr), .O_sram_ce_n(d3_ce_n), .O_sram_oe_n(d3_oe_n),
    .O_sram_we_n(d3_we_n), .O_sram_ub_n(d3_ub_n), .O_sram_lb_n(d3_lb_n),
    .O_sram_dat(d3_dat), .O_sram_dat_oe(d3_doe), .I_sram_dat(d3_in)
  );

  // Async SRAM model: reads drive only while CE and OE are low; a write
  // commits the enabled lanes on the rising edge of WE.
  assign d1_in = (!d1_ce_n && !d1_oe_n) ? mem[d1_adr] : 16'hxxxx;
  assign d3_in = (!d3_ce_n && !d3_oe_n) ? mem[d3_adr] : 16'hxxxx;

  always @(posedge d1_we_n) begin
    if (rst_n && !d1_ce_n) begin
      if (!d1_lb_n) mem[d1_adr][7:0]  <= d1_dat[7:0];
      if (!d1_ub_n) mem[d1_adr][15:8] <= d1_dat[15:8];
    end
  end

  // Observed view of whichever instance is selected.
  logic [15:0] o_adr, o_dat;
  logic        o_ce_n, o_oe_n, o_we_n, o_ub_n, o_lb_n, o_doe, o_ack;
  logic [7:0]  o_rd;
  assign o_adr  = sel ? d3_adr  : d1_adr;
  assign o_dat  = sel ? d3_dat  : d1_dat;
  assign o_ce_n = sel ? d3_ce_n : d1_ce_n;
  assign o_oe_n = sel ? d3_oe_n : d1_oe_n;
  assign o_we_n = sel ? d3_we_n : d1_we_n;
  assign o_ub_n = sel ? d3_ub_n : d1_ub_n;
  assign o_lb_n = sel ? d3_lb_n : d1_lb_n;
  assign o_doe  = sel ? d3_doe  : d1_doe;
  assign o_ack  = sel ? wb3.ACK_O : wb1.ACK_O;
  assign o_rd   = sel ? wb3.DAT_O : wb1.DAT_O;

  int overlap = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (d1_doe && !d1_oe_n) overlap <= overlap + 1;
      if (d3_doe && !d3_oe_n) overlap <= overlap + 1;
    end
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Per-access trace: bit c-1 of each mask is the strobe state in cycle c.
  int          ack_cyc, ack_cnt;
  logic [11:0] we_mask, oe_mask, ce_mask, doe_mask;
  logic [15:0] snap_adr, snap_dat;
  logic [1:0]  snap_lanes;
  logic [7:0]  rd_at_ack;

  task automatic access(input logic sel_i, input logic we_i, input logic [16:0] adr_i,
                        input logic [7:0] dat_i, input logic drop);
    sel = sel_i;
    @(negedge clk);
    stb = 1'b1; we = we_i; adr = adr_i; dat = dat_i;
    ack_cyc = -1; ack_cnt = 0; rd_at_ack = 8'h00;
    we_mask = '0; oe_mask = '0; ce_mask = '0; doe_mask = '0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) begin
        snap_adr = o_adr; snap_dat = o_dat; snap_lanes = {o_ub_n, o_lb_n};
        if (drop) stb = 1'b0;
      end
      we_mask[c-1]  = !o_we_n;
      oe_mask[c-1]  = !o_oe_n;
      ce_mask[c-1]  = !o_ce_n;
      doe_mask[c-1] = o_doe;
      if (o_ack) begin
        ack_cnt++;
        if (ack_cyc < 0) begin
          ack_cyc = c;
          rd_at_ack = o_rd;
        end
        stb = 1'b0;
      end
    end
  endtask

  int          b2b_acks;
  int          ack_at [0:3];
  logic [7:0]  b2b_rd [0:1];
  int          exp_ack [0:3];
  logic        cur_we;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] <= 16'h0000;
    mem[16'h0000] <= 16'h1234;
    mem[16'hFFFF] <= 16'h7711;
    mem[16'h0030] <= 16'hC300;
    exp_ack = '{3, 6, 10, 13};

    repeat (2) @(negedge clk);
    chk("rst_strobes", 32'({d1_ce_n, d1_oe_n, d1_we_n, d1_ub_n, d1_lb_n}), 32'h1F);
    chk("rst_dat_oe", 32'(d1_doe), 32'h0);
    chk("rst_ack", 32'(wb1.ACK_O), 32'h0);
    chk("rst_dat_o", 32'(wb1.DAT_O), 32'h00);
    chk("rst_adr", 32'(d1_adr), 32'h0);
    chk("rst_sram_dat", 32'(d1_dat), 32'h0);
    rst_n = 1'b1;

    // Write upper lane
    access(1'b0, 1'b1, 17'h00001, 8'hA5, 1'b0);
    chk("wr_up_adr", 32'(snap_adr), 32'h0000);
    chk("wr_up_lanes", 32'(snap_lanes), 32'h1);
    chk("wr_up_dat", 32'(snap_dat), 32'hA5A5);
    chk("wr_up_we_mask", 32'(we_mask), 32'h001);
    chk("wr_up_doe_mask", 32'(doe_mask), 32'h003);
    chk("wr_up_ce_mask", 32'(ce_mask), 32'h003);
    chk("wr_up_ack_cyc", 32'(ack_cyc), 32'd3);
    chk("wr_up_ack_cnt", 32'(ack_cnt), 32'd1);
    chk("wr_up_mem", 32'(mem[16'h0000]), 32'hA534);

    // Lane independence
    access(1'b0, 1'b1, 17'h00000, 8'h3C, 1'b0);
    chk("wr_lo_mem", 32'(mem[16'h0000]), 32'hA53C);
    access(1'b0, 1'b0, 17'h00000, 8'h00, 1'b0);
    chk("rd_lo_dat", 32'(rd_at_ack), 32'h3C);
    chk("rd_lo_ack_cyc", 32'(ack_cyc), 32'd2);
    chk("rd_lo_lanes", 32'(snap_lanes), 32'h2);
    chk("rd_lo_oe_mask", 32'(oe_mask), 32'h001);
    access(1'b0, 1'b0, 17'h00001, 8'h00, 1'b0);
    chk("rd_up_dat", 32'(rd_at_ack), 32'hA5);
    chk("rd_up_ack_cyc", 32'(ack_cyc), 32'd2);

    // Wait states, N=3, top of address space
    access(1'b1, 1'b0, 17'h1FFFF, 8'h00, 1'b0);
    chk("ws_oe_mask", 32'(oe_mask), 32'h007);
    chk("ws_ack_cyc", 32'(ack_cyc), 32'd4);
    chk("ws_dat", 32'(rd_at_ack), 32'h77);
    chk("ws_adr", 32'(snap_adr), 32'hFFFF);
    chk("ws_ack_cnt", 32'(ack_cnt), 32'd1);

    // Back-to-back with STB_I held high: W, R, W, R
    sel = 1'b0;
    @(negedge clk);
    stb = 1'b1; we = 1'b1; adr = 17'h00010; dat = 8'h11;
    b2b_acks = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (o_ack) begin
        cur_we = we;
        if (b2b_acks < 4) ack_at[b2b_acks] = c;
        if (!cur_we && b2b_acks == 1) b2b_rd[0] = o_rd;
        if (!cur_we && b2b_acks == 3) b2b_rd[1] = o_rd;
        b2b_acks++;
        case (b2b_acks)
          1: begin we = 1'b0; adr = 17'h00010; dat = 8'h00; end
          2: begin we = 1'b1; adr = 17'h00011; dat = 8'h22; end
          3: begin we = 1'b0; adr = 17'h00011; dat = 8'h00; end
          default: stb = 1'b0;
        endcase
      end
    end
    chk("b2b_ack_cnt", 32'(b2b_acks), 32'd4);
    for (int k = 0; k < 4; k++) chk($sformatf("b2b_ack_cyc%0d", k), 32'(ack_at[k]), 32'(exp_ack[k]));
    chk("b2b_rd0", 32'(b2b_rd[0]), 32'h11);
    chk("b2b_rd1", 32'(b2b_rd[1]), 32'h22);
    chk("b2b_mem", 32'(mem[16'h0008]), 32'h2211);

    // Reset asserted during cycle 1 of a write
    sel = 1'b0;
    @(negedge clk);
    stb = 1'b1; we = 1'b1; adr = 17'h00040; dat = 8'h99;
    @(negedge clk);
    chk("rstw_pre_we_n", 32'(d1_we_n), 32'h0);
    #1 rst_n = 1'b0;
    stb = 1'b0;
    #1;
    chk("rstw_we_ce", 32'({d1_we_n, d1_ce_n}), 32'h3);
    chk("rstw_dat_oe", 32'(d1_doe), 32'h0);
    chk("rstw_ack", 32'(wb1.ACK_O), 32'h0);
    chk("rstw_dat_o", 32'(wb1.DAT_O), 32'h00);
    chk("rstw_adr", 32'(d1_adr), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rstw_mem_untouched", 32'(mem[16'h0020]), 32'h0000);
    access(1'b0, 1'b0, 17'h00061, 8'h00, 1'b0);
    chk("rstw_rd_dat", 32'(rd_at_ack), 32'hC3);
    chk("rstw_rd_ack_cyc", 32'(ack_cyc), 32'd2);

    // Strobe dropped after cycle 0 of a read
    access(1'b0, 1'b0, 17'h00000, 8'h00, 1'b1);
    chk("drop_ack_cyc", 32'(ack_cyc), 32'd2);
    chk("drop_ack_cnt", 32'(ack_cnt), 32'd1);
    chk("drop_dat", 32'(rd_at_ack), 32'h3C);
    chk("drop_ce_mask", 32'(ce_mask), 32'h001);

    chk("no_oe_dat_overlap", 32'(overlap), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
